// File: rtl/mmio_stream_pkg.sv
// Shared constants for the MMIO stream port: register offsets, STATUS/CTRL bit
// positions and the STATUS word packer.
package mmio_stream_pkg;

    localparam logic [3:0] OFS_TXDATA = 4'h0;
    localparam logic [3:0] OFS_RXDATA = 4'h4;
    localparam logic [3:0] OFS_STATUS = 4'h8;
    localparam logic [3:0] OFS_CTRL   = 4'hC;

    // Word index of each register, as seen on ADDR[3:2].
    typedef enum logic [1:0] {
        REG_TXDATA = OFS_TXDATA[3:2],
        REG_RXDATA = OFS_RXDATA[3:2],
        REG_STATUS = OFS_STATUS[3:2],
        REG_CTRL   = OFS_CTRL[3:2]
    } reg_sel_e;

    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_RX_FULL     = 2;
    localparam int ST_RX_EMPTY    = 3;
    localparam int ST_TX_OVERFLOW = 4;
    localparam int ST_RX_UNDERFLW = 5;
    localparam int ST_TX_CNT_LSB  = 8;
    localparam int ST_RX_CNT_LSB  = 16;

    localparam int CTRL_FLUSH_TX  = 0;
    localparam int CTRL_FLUSH_RX  = 1;
    localparam int CTRL_CLR_FLAGS = 2;

    function automatic logic [31:0] pack_status(
        input logic       tx_full,
        input logic       tx_empty,
        input logic       rx_full,
        input logic       rx_empty,
        input logic       tx_overflow,
        input logic       rx_underflow,
        input logic [7:0] tx_cnt,
        input logic [7:0] rx_cnt
    );
        logic [31:0] s;
        s                         = '0;
        s[ST_TX_FULL]             = tx_full;
        s[ST_TX_EMPTY]            = tx_empty;
        s[ST_RX_FULL]             = rx_full;
        s[ST_RX_EMPTY]            = rx_empty;
        s[ST_TX_OVERFLOW]         = tx_overflow;
        s[ST_RX_UNDERFLW]         = rx_underflow;
        s[ST_TX_CNT_LSB +: 8]     = tx_cnt;
        s[ST_RX_CNT_LSB +: 8]     = rx_cnt;
        return s;
    endfunction

endpackage

// File: rtl/mmio_stream_port_fifo.sv
// Synchronous FIFO with flush; also exposes the state it will have after this
// cycle's pop/push/flush so the bus read path can sample post-commit values.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head,
    output logic [WIDTH-1:0]           next_head,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     next_count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_inc;
    logic             push_acc;
    logic             pop_acc;

    assign full       = (count == DEPTH_C);
    assign empty      = (count == '0);
    assign rd_ptr_inc = rd_ptr + AW'(1);

    // Flush wins over everything; a push into a full FIFO needs a same-cycle pop.
    assign pop_acc  = pop & ~empty & ~flush;
    assign push_acc = push & (~full | pop_acc) & ~flush;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        next_count = count + (AW+1)'(push_acc) - (AW+1)'(pop_acc);
        if (flush) begin
            next_count = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            count <= next_count;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_acc) wr_ptr <= wr_ptr + AW'(1);
                if (pop_acc)  rd_ptr <= rd_ptr_inc;
            end
        end
    end

    // NOTE: storage has no reset; the count/empty gating makes stale words invisible.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign head = empty ? '0 : mem[rd_ptr];

    // Post-pop head of already-stored data; a same-cycle push is not folded in.
    always_comb begin
        next_head = head;
        if (flush) begin
            next_head = '0;
        end else if (pop_acc) begin
            next_head = (count > (AW+1)'(1)) ? mem[rd_ptr_inc] : '0;
        end
    end

endmodule

// File: rtl/mmio_stream_port.sv
// MMIO slave bridging CPU loads/stores to a TX and an RX stream FIFO.
// Address is sampled one cycle before the CS/WR_RD commit cycle.
module mmio_stream_port
    import mmio_stream_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
    parameter int          DEPTH     = 8,
    parameter int          AW        = $clog2(DEPTH)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ADDR,
    input  logic [31:0] Data_BUS_WRITE,
    input  logic        CS,
    input  logic        WR_RD,
    output logic [31:0] Data_BUS_READ,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    reg_sel_e    a_q;
    logic [31:0] wd_q;
    logic        hit_q;
    logic        pop_ok_q;
    logic        tx_overflow;
    logic        rx_underflow;

    logic        commit;
    logic        tx_push;
    logic        ctrl_wr;
    logic        tx_flush;
    logic        rx_flush;
    logic        flag_clr;
    logic        rx_load;
    logic        rx_pop;
    logic        ovf_set;
    logic        udf_set;
    logic        tx_overflow_next;
    logic        rx_underflow_next;

    logic [AW:0]  tx_count, tx_next_count, rx_count, rx_next_count, rx_avail;
    logic         tx_full, tx_empty, rx_full, rx_empty;
    logic [31:0]  rx_head, rx_next_head, tx_unused_head;

    reg_sel_e    sel;
    logic        match;
    logic [31:0] status;
    logic [31:0] rd_next;
    logic        pop_ok_next;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^ADDR[1:0];

    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;

    // Commit-cycle decode of the access sampled on the previous cycle.
    always_comb begin
        commit   = CS & hit_q;
        tx_push  = commit & WR_RD & (a_q == REG_TXDATA);
        ctrl_wr  = commit & WR_RD & (a_q == REG_CTRL);
        tx_flush = ctrl_wr & wd_q[CTRL_FLUSH_TX];
        rx_flush = ctrl_wr & wd_q[CTRL_FLUSH_RX];
        flag_clr = ctrl_wr & wd_q[CTRL_CLR_FLAGS];
        rx_load  = commit & ~WR_RD & (a_q == REG_RXDATA);
        rx_pop   = rx_load & pop_ok_q;
        udf_set  = rx_load & ~pop_ok_q;
        ovf_set  = tx_push & tx_full & ~(tx_valid & tx_ready) & ~tx_flush;

        tx_overflow_next  = (tx_overflow & ~flag_clr) | ovf_set;
        rx_underflow_next = (rx_underflow & ~flag_clr) | udf_set;
    end

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tx_fifo (
        .clk        (CLK),
        .rst        (RST),
        .push       (tx_push),
        .pop        (tx_ready),
        .flush      (tx_flush),
        .wdata      (wd_q),
        .head       (tx_data),
        .next_head  (tx_unused_head),
        .count      (tx_count),
        .next_count (tx_next_count),
        .full       (tx_full),
        .empty      (tx_empty)
    );

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rx_fifo (
        .clk        (CLK),
        .rst        (RST),
        .push       (rx_valid & rx_ready),
        .pop        (rx_pop),
        .flush      (rx_flush),
        .wdata      (rx_data),
        .head       (rx_head),
        .next_head  (rx_next_head),
        .count      (rx_count),
        .next_count (rx_next_count),
        .full       (rx_full),
        .empty      (rx_empty)
    );

    // Read sample: post-commit view. RX words arriving this same cycle are
    // deliberately excluded from what a load may pop.
    always_comb begin
        sel      = reg_sel_e'(ADDR[3:2]);
        match    = (ADDR[31:4] == BASE_ADDR[31:4]);
        rx_avail = rx_flush ? '0 : (rx_count - (AW+1)'(rx_pop));
        status   = pack_status(tx_next_count == DEPTH_C,
                               tx_next_count == '0,
                               rx_next_count == DEPTH_C,
                               rx_next_count == '0,
                               tx_overflow_next,
                               rx_underflow_next,
                               8'(tx_next_count),
                               8'(rx_next_count));
        rd_next     = '0;
        pop_ok_next = 1'b0;
        if (match) begin
            case (sel)
                REG_RXDATA: begin
                    pop_ok_next = (rx_avail != '0);
                    rd_next     = pop_ok_next ? rx_next_head : '0;
                end
                REG_STATUS: rd_next = status;
                default:    rd_next = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q           <= REG_TXDATA;
            wd_q          <= '0;
            hit_q         <= 1'b0;
            pop_ok_q      <= 1'b0;
            Data_BUS_READ <= '0;
            tx_overflow   <= 1'b0;
            rx_underflow  <= 1'b0;
        end else begin
            a_q           <= sel;
            wd_q          <= Data_BUS_WRITE;
            hit_q         <= match;
            pop_ok_q      <= pop_ok_next;
            Data_BUS_READ <= rd_next;
            tx_overflow   <= tx_overflow_next;
            rx_underflow  <= rx_underflow_next;
        end
    end

endmodule

// File: tb/tb_mmio_stream_port.sv
// Directed bench for mmio_stream_port: a vector table for plain register
// accesses, then hand-written sequences for the multi-cycle corner cases.
module tb_mmio_stream_port;

    localparam logic [31:0] BASE = 32'h0000_0400;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic        CS;
    logic        WR_RD;
    logic [31:0] Data_BUS_READ;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int n_vec = 0;
    int n_err = 0;

    mmio_stream_port #(.BASE_ADDR(BASE), .DEPTH(8), .AW(3)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .ADDR           (ADDR),
        .Data_BUS_WRITE (Data_BUS_WRITE),
        .CS             (CS),
        .WR_RD          (WR_RD),
        .Data_BUS_READ  (Data_BUS_READ),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        wr;
        logic [3:0]  ofs;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_txv;
        logic [31:0] exp_txd;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // One non-pipelined access; entered and left at posedge+1.
    task automatic bus(input logic wr, input logic [3:0] ofs, input logic [31:0] wd,
                       output logic [31:0] rd);
        ADDR           = BASE + {28'h0, ofs};
        Data_BUS_WRITE = wd;
        CS             = 1'b0;
        WR_RD          = 1'b0;
        @(posedge CLK); #1;
        CS    = 1'b1;
        WR_RD = wr;
        ADDR  = 32'h0;
        @(negedge CLK);
        rd = Data_BUS_READ;
        @(posedge CLK); #1;
        CS    = 1'b0;
        WR_RD = 1'b0;
    endtask

    task automatic wr_reg(input logic [3:0] ofs, input logic [31:0] wd);
        logic [31:0] dummy;
        bus(1'b1, ofs, wd, dummy);
    endtask

    task automatic rd_check(input logic [3:0] ofs, input logic [31:0] exp, input string name);
        logic [31:0] rd;
        bus(1'b0, ofs, 32'h0, rd);
        check(name, rd, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{"rst_status",   1'b0, 4'h8, 32'h0,        32'h0000_000A, 1'b0, 32'h0};
        vecs[1] = '{"rd_txdata_wo", 1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 32'h0};
        vecs[2] = '{"rd_ctrl_wo",   1'b0, 4'hC, 32'h0,        32'h0,         1'b0, 32'h0};
        vecs[3] = '{"push_11",      1'b1, 4'h0, 32'h11,       32'h0,         1'b1, 32'h11};
        vecs[4] = '{"push_22",      1'b1, 4'h0, 32'h22,       32'h0,         1'b1, 32'h11};
        vecs[5] = '{"push_33",      1'b1, 4'h0, 32'h33,       32'h0,         1'b1, 32'h11};
        vecs[6] = '{"wr_status_ro", 1'b1, 4'h8, 32'hFFFF_FFFF, 32'h0,        1'b1, 32'h11};
        vecs[7] = '{"status_tx3",   1'b0, 4'h8, 32'h0,        32'h0000_0308, 1'b1, 32'h11};
        vecs[8] = '{"rd_rx_at_tx3", 1'b0, 4'h0, 32'h0,        32'h0,         1'b1, 32'h11};

        RST = 1'b1; ADDR = '0; Data_BUS_WRITE = '0; CS = 1'b0; WR_RD = 1'b0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
        check("rst_tx_data",  tx_data, 32'h0);

        for (int i = 0; i < 9; i++) begin
            logic [31:0] rd;
            bus(vecs[i].wr, vecs[i].ofs, vecs[i].wd, rd);
            if (!vecs[i].wr) check($sformatf("%s.rd", vecs[i].name), rd, vecs[i].exp_rd);
            check($sformatf("%s.txv", vecs[i].name), {31'b0, tx_valid}, {31'b0, vecs[i].exp_txv});
            check($sformatf("%s.txd", vecs[i].name), tx_data, vecs[i].exp_txd);
        end

        // TX drains on consecutive cycles once tx_ready rises.
        tx_ready = 1'b1;
        @(negedge CLK); check("drain_0", {tx_valid, tx_data[30:0]}, {1'b1, 31'h11});
        @(negedge CLK); check("drain_1", {tx_valid, tx_data[30:0]}, {1'b1, 31'h22});
        @(negedge CLK); check("drain_2", {tx_valid, tx_data[30:0]}, {1'b1, 31'h33});
        @(negedge CLK); check("drain_end_txv", {31'b0, tx_valid}, 32'd0);
        tx_ready = 1'b0;
        @(posedge CLK); #1;

        // Stream in two words, then two pipelined RXDATA loads.
        rx_valid = 1'b1; rx_data = 32'hA1;
        @(posedge CLK); #1 rx_data = 32'hA2;
        @(posedge CLK); #1 rx_valid = 1'b0;
        ADDR = BASE + 32'h4;
        @(posedge CLK); #1 CS = 1'b1; WR_RD = 1'b0;
        @(negedge CLK); check("b2b_rx_0", Data_BUS_READ, 32'hA1);
        @(posedge CLK); #1 ADDR = 32'h0;
        @(negedge CLK); check("b2b_rx_1", Data_BUS_READ, 32'hA2);
        @(posedge CLK); #1 CS = 1'b0;
        rd_check(4'h8, 32'h0000_000A, "status_after_b2b");

        // Fill TX, overflow, clear flags, then push-while-full with a stream pop.
        for (int i = 0; i < 8; i++) wr_reg(4'h0, 32'h100 + i);
        check("full_head", tx_data, 32'h100);
        wr_reg(4'h0, 32'hDEAD);
        rd_check(4'h8, 32'h0000_0819, "status_overflow");
        wr_reg(4'hC, 32'h4);
        rd_check(4'h8, 32'h0000_0809, "status_ovf_cleared");
        ADDR = BASE; Data_BUS_WRITE = 32'hBEEF;
        @(posedge CLK); #1 CS = 1'b1; WR_RD = 1'b1; ADDR = 32'h0; tx_ready = 1'b1;
        @(posedge CLK); #1 CS = 1'b0; WR_RD = 1'b0; tx_ready = 1'b0;
        check("full_push_pop_head", tx_data, 32'h101);
        rd_check(4'h8, 32'h0000_0809, "status_full_push_pop");
        wr_reg(4'hC, 32'h1);
        rd_check(4'h8, 32'h0000_000A, "status_tx_flushed");

        // RXDATA load on empty FIFO while a word arrives in the commit cycle.
        ADDR = BASE + 32'h4;
        @(posedge CLK); #1 CS = 1'b1; WR_RD = 1'b0; ADDR = 32'h0;
        rx_valid = 1'b1; rx_data = 32'h55;
        @(negedge CLK); check("underflow_rd", Data_BUS_READ, 32'h0);
        @(posedge CLK); #1 CS = 1'b0; rx_valid = 1'b0;
        rd_check(4'h8, 32'h0001_0022, "status_underflow");
        rd_check(4'h4, 32'h0000_0055, "rx_after_underflow");
        rd_check(4'h8, 32'h0000_002A, "status_udf_sticky");
        wr_reg(4'hC, 32'h4);
        rd_check(4'h8, 32'h0000_000A, "status_udf_cleared");

        // RX flush.
        rx_valid = 1'b1; rx_data = 32'h77;
        @(posedge CLK); #1 rx_valid = 1'b0;
        rd_check(4'h8, 32'h0001_0002, "status_rx_one");
        wr_reg(4'hC, 32'h2);
        rd_check(4'h8, 32'h0000_000A, "status_rx_flushed");

        // Asynchronous reset in the middle of a STATUS load with 5 TX entries.
        for (int i = 0; i < 5; i++) wr_reg(4'h0, 32'h201 + i);
        ADDR = BASE + 32'h8;
        @(posedge CLK); #1 CS = 1'b1; WR_RD = 1'b0; ADDR = 32'h0;
        @(negedge CLK); check("pre_rst_status", Data_BUS_READ, 32'h0000_0508);
        #1 RST = 1'b1;
        #1;
        check("mid_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("mid_rst_rd",       Data_BUS_READ, 32'h0);
        check("mid_rst_tx_data",  tx_data, 32'h0);
        check("mid_rst_rx_ready", {31'b0, rx_ready}, 32'd1);
        CS = 1'b0;
        @(posedge CLK); #1 RST = 1'b0;
        @(posedge CLK); #1;
        rd_check(4'h8, 32'h0000_000A, "post_rst_status");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
